// File: rtl/mem_refill_responder_pkg.sv
// rtl/mem_refill_responder_pkg.sv - shared constants and FSM encoding for the refill responder
package mem_refill_responder_pkg;

  localparam int ADR_WIDTH    = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int WORD_OFFSET  = 2;
  localparam int BEATS        = 1 << WORD_OFFSET;
  localparam int MEM_ADR_BITS = 10;
  localparam int LATENCY      = 4;

  // Plain vector encoding so legacy code comparing raw state bits keeps working
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WAIT  = 2'd1;
  localparam state_t S_BURST = 2'd2;
  localparam state_t S_GAP   = 2'd3;

endpackage

// File: rtl/mem_refill_responder_if.sv
// rtl/mem_refill_responder_if.sv - cache-to-memory refill request/response bundle
interface mem_refill_responder_if #(
  parameter int ADR_WIDTH  = mem_refill_responder_pkg::ADR_WIDTH,
  parameter int DATA_WIDTH = mem_refill_responder_pkg::DATA_WIDTH
);

  logic                  req_cc2mem;
  logic [ADR_WIDTH-1:0]  adr_cc2mem;
  logic                  ack_mem2cc;
  logic [DATA_WIDTH-1:0] dat_mem2cc;

  // Cache controller side
  modport master (
    output req_cc2mem,
    output adr_cc2mem,
    input  ack_mem2cc,
    input  dat_mem2cc
  );

  // Memory side
  modport slave (
    input  req_cc2mem,
    input  adr_cc2mem,
    output ack_mem2cc,
    output dat_mem2cc
  );

endinterface

// File: rtl/mem_refill_responder_ram.sv
// rtl/mem_refill_responder_ram.sv - word RAM with one synchronous read port and one write port
module mem_refill_ram
  import mem_refill_responder_pkg::*;
#(
  parameter int AW = MEM_ADR_BITS,
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Both ports update with non-blocking assignments, so a same-edge read of the written word sees the old data
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wadr] <= wdat;
    end
    r_rdata <= r_mem[radr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_refill_responder.sv
// rtl/mem_refill_responder.sv - latency-delayed line refill responder backed by a loadable word RAM
module mem_refill_responder #(
  parameter int ADR_WIDTH    = mem_refill_responder_pkg::ADR_WIDTH,
  parameter int DATA_WIDTH   = mem_refill_responder_pkg::DATA_WIDTH,
  parameter int WORD_OFFSET  = mem_refill_responder_pkg::WORD_OFFSET,
  parameter int MEM_ADR_BITS = mem_refill_responder_pkg::MEM_ADR_BITS,
  parameter int LATENCY      = mem_refill_responder_pkg::LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_refill_responder_if.slave   bus,
  input  logic                    ld_we,
  input  logic [MEM_ADR_BITS-1:0] ld_adr,
  input  logic [DATA_WIDTH-1:0]   ld_dat,
  output logic                    busy
);

  import mem_refill_responder_pkg::*;

  localparam int                 LINE_BITS = MEM_ADR_BITS - WORD_OFFSET;
  localparam int                 LINE_BEATS = 1 << WORD_OFFSET;
  localparam logic [7:0]         LAT_INIT  = 8'(LATENCY - 1);
  localparam logic [WORD_OFFSET:0] LAST_CNT = (WORD_OFFSET + 1)'(LINE_BEATS);

  state_t                  r_state;
  logic [7:0]              r_lat;
  // Number of RAM reads issued for the current line; one extra bit marks the last beat on display
  logic [WORD_OFFSET:0]    r_beat;
  logic [LINE_BITS-1:0]    r_line;
  logic                    r_ack;

  logic [MEM_ADR_BITS-1:0] w_rd_adr;
  logic [DATA_WIDTH-1:0]   w_rdata;

  // Only the low beat bits reach the RAM address, so the walk wraps inside the line
  assign w_rd_adr = {r_line, r_beat[WORD_OFFSET-1:0]};

  mem_refill_ram #(
    .AW (MEM_ADR_BITS),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ld_we),
    .wadr  (ld_adr),
    .wdat  (ld_dat),
    .radr  (w_rd_adr),
    .rdata (w_rdata)
  );

  // Refill FSM: latch the line, count down the latency, stream the beats, then wait for req to drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
      r_line  <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_cc2mem) begin
            r_state <= S_WAIT;
            r_line  <= bus.adr_cc2mem[MEM_ADR_BITS+1:WORD_OFFSET+2];
            r_lat   <= LAT_INIT;
            r_beat  <= '0;
          end
        end
        S_WAIT: begin
          // The edge leaving WAIT also issues the read of word 0, so data and ack rise together
          if (r_lat == 8'd0) begin
            r_state <= S_BURST;
            r_ack   <= 1'b1;
            r_beat  <= r_beat + 1'b1;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end
        S_BURST: begin
          if (r_beat == LAST_CNT) begin
            r_state <= S_GAP;
            r_ack   <= 1'b0;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_GAP: begin
          // A request still held from the finished burst must not start another one
          if (!bus.req_cc2mem) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_mem2cc = r_ack;
  assign bus.dat_mem2cc = r_ack ? w_rdata : '0;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: doc/mem_refill_responder.md
Name: mem_refill_responder

Overview:
- Memory-side responder for the cache controller's refill interface: answers req_cc2mem/adr_cc2mem with a latency-delayed burst of 2^WORD_OFFSET words on ack_mem2cc/dat_mem2cc.
- Backed by an internal word RAM that a side load port can write.
- Replaces hand-written refill tasks in benches.
- Serves as the synthesizable main-memory stub on the cache's memory side.

Parameters:
- ADR_WIDTH, 32, byte address width of adr_cc2mem.
- DATA_WIDTH, 32, word width.
- WORD_OFFSET, 2, log2 of words per line; BEATS = 2^WORD_OFFSET (4).
- MEM_ADR_BITS, 10, log2 of RAM depth in words (1024).
- LATENCY, 4, cycles from request sample to first ack; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_cc2mem  in  1  refill request from the cache controller.
- adr_cc2mem  in  ADR_WIDTH  byte address of the missing word.
- ack_mem2cc  out  1  beat valid, one per word.
- dat_mem2cc  out  DATA_WIDTH  beat data, valid while ack_mem2cc=1.
- ld_we  in  1  load-port write enable.
- ld_adr  in  MEM_ADR_BITS  load-port word address.
- ld_dat  in  DATA_WIDTH  load-port write data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: async assert forces IDLE and clears beat counter and latency counter. Outputs go to ack_mem2cc=0, dat_mem2cc=0, busy=0 immediately. RAM contents are not reset.
- FSM states:
  - IDLE: req_cc2mem=1 sampled at edge N goes to WAIT. Latch line base = adr_cc2mem[MEM_ADR_BITS+1:2] with the low WORD_OFFSET bits forced to 0. Load latency counter with LATENCY-1.
  - WAIT: counter decrements each edge. When it is 0, go to BURST. LATENCY=1 means BURST is entered at edge N+1.
  - BURST: ack_mem2cc=1 for exactly BEATS consecutive cycles. Beat k (0..BEATS-1) carries RAM[line_base+k].
    - Order is sequential from word 0 of the line, not critical-word-first.
    - The counter wraps within the line only; it never carries into the tag bits.
    - After the last beat: ack_mem2cc=0 and go to GAP.
  - GAP: stay until req_cc2mem=0 is sampled, then go to IDLE. This prevents a held request from re-triggering.
- Latency: with req sampled at edge N, ack_mem2cc rises at edge N+LATENCY and falls at edge N+LATENCY+BEATS. New requests are accepted no earlier than the edge after req drops.
- Outputs are registered. dat_mem2cc is driven from a registered RAM read issued one cycle ahead, so data and ack change on the same edge. dat_mem2cc returns to 0 when ack_mem2cc=0.
- Address handling:
  - Bits [1:0] are ignored.
  - Bits above MEM_ADR_BITS+1 are ignored, so addresses alias modulo RAM size.
  - adr_cc2mem is sampled only in IDLE; later changes have no effect.
- req dropped mid-WAIT or mid-BURST: the burst still completes in full (no abort), then FSM passes through GAP to IDLE.
- Load port:
  - Writes RAM[ld_adr] on any edge, in any state.
  - Same-cycle load write and burst read of the same word: the read returns the old data (read-before-write).
  - A write to a later beat of an in-flight line is visible if it lands at least one cycle before that beat's read is issued.
- Reset asserted mid-burst: ack drops asynchronously and no further beats are sent. Contents written by the load port are kept.

Decomposition:
- Shared package holds:
  - FSM state typedef {IDLE, WAIT, BURST, GAP}.
  - Constants ADR_WIDTH, DATA_WIDTH, WORD_OFFSET, and BEATS derived as 1<<WORD_OFFSET. These are shared with cacheController.
- One sub-module: mem_refill_ram.
  - Single clock, one synchronous read port plus one write port, read-before-write, MEM_ADR_BITS x DATA_WIDTH.
  - The responder keeps the FSM, latency counter and beat counter.

Test Plan:
- Load RAM[0x040..0x043]=0xA0,0xA1,0xA2,0xA3. Request adr 0x0000_0108 with LATENCY=4, req sampled at edge N -> ack high at edges N+4..N+7. dat sequence A0,A1,A2,A3. busy high from N+1 until req is seen low.
- Request adr 0xFF07_BD0C: RAM index 0x343 (bits [11:2], line base 0x340). Load RAM[0x340..0x343]=1..4 -> beats 1,2,3,4. Upper address bits are ignored.
- Hold req_cc2mem high for 20 cycles after the burst -> exactly 4 acks total. A new burst starts only after req is low for one sampled edge and then high again.
- Assert rst during the 2nd beat -> ack_mem2cc and dat_mem2cc are 0 before the next edge and state is IDLE. A following request gets 4 beats with unchanged RAM data.
- During WAIT, ld_we writes RAM[line_base+3]=0xDEAD -> beat 3 returns 0xDEAD. A write to beat 0's word in the same cycle as its read returns the old value.
- Build with LATENCY=1 and issue back-to-back requests -> ack at N+1..N+4 for each, with a GAP of at least one cycle between bursts.
